alu_exec_unit: RTL and testbench

Parametrised successor to the single-cycle ALU-op decoder. It decodes Aluop/funct into an ALU operation and executes it on registered operands. Base RV32I ops complete in 1 cycle. Optional M-subset ops (MUL, DIVU, REMU) run iteratively over XLEN cycles under a valid/ready handshake. The block sits in the EX stage; the hazard unit stalls ID/EX while busy is high and drives flush on branch mispredict.

---
 rtl/alu_exec_unit.sv | 215 +++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes aluop/funct and executes base ops in one cycle.
// MUL/DIVU/REMU iterate one bit per cycle; in_ready drops while busy, outputs have no backpressure.
module alu_exec_unit #(
  parameter int XLEN   = 32,
  parameter bit EN_MDU = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      aluop,
  input  logic [4:0]      funct,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic [3:0]      operation,
  output logic            busy
);
  localparam int CW = $clog2(XLEN);

  localparam logic [3:0] OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011, OP_SLL  = 4'b0100, OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110, OP_SRA  = 4'b0111, OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001, OP_MUL  = 4'b1010, OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_acc, r_mcand, r_mpl;
  logic [XLEN-1:0] r_quo, r_rem, r_div;
  logic            r_is_rem;
  logic            r_out_valid;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_illegal;
  logic [3:0]      r_operation;

  logic [3:0]      w_op;
  logic            w_ill;
  logic [XLEN-1:0] w_res;
  logic [CW-1:0]   w_shamt;
  logic            w_accept;
  logic            w_iter;
  logic [XLEN-1:0] w_acc_nxt;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_rem_sub;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;

  always_comb begin
    w_op  = OP_ADD;
    w_ill = 1'b0;
    case (aluop)
      2'b00: w_op = OP_ADD;
      2'b01: w_op = OP_SUB;
      2'b10: begin
        case (funct)
          5'b00000: w_op = OP_ADD;
          5'b10000: w_op = OP_SUB;
          5'b00111: w_op = OP_AND;
          5'b00110: w_op = OP_OR;
          5'b00100: w_op = OP_XOR;
          5'b00001: w_op = OP_SLL;
          5'b00101: w_op = OP_SRL;
          5'b10101: w_op = OP_SRA;
          5'b00010: w_op = OP_SLT;
          5'b00011: w_op = OP_SLTU;
          5'b01000: if (EN_MDU) w_op = OP_MUL;  else w_ill = 1'b1;
          5'b01101: if (EN_MDU) w_op = OP_DIVU; else w_ill = 1'b1;
          5'b01111: if (EN_MDU) w_op = OP_REMU; else w_ill = 1'b1;
          default:  w_ill = 1'b1;
        endcase
      end
      default: begin
        // I-type: funct3 alone selects the op, funct7[5] only picks SRA over SRL
        case (funct[2:0])
          3'b000:  w_op = OP_ADD;
          3'b101:  w_op = funct[4] ? OP_SRA : OP_SRL;
          3'b111:  w_op = OP_AND;
          3'b110:  w_op = OP_OR;
          3'b100:  w_op = OP_XOR;
          3'b001:  w_op = OP_SLL;
          3'b010:  w_op = OP_SLT;
          default: w_op = OP_SLTU;
        endcase
      end
    endcase
  end

  assign w_shamt = b[CW-1:0];

  always_comb begin
    w_res = '0;
    case (w_op)
      OP_ADD:  w_res = a + b;
      OP_SUB:  w_res = a - b;
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_SLL:  w_res = a << w_shamt;
      OP_SRL:  w_res = a >> w_shamt;
      OP_SRA:  w_res = $signed(a) >>> w_shamt;
      OP_SLT:  w_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_res = {{(XLEN-1){1'b0}}, (a < b)};
      OP_DIVU: w_res = '1;
      OP_REMU: w_res = a;
      default: w_res = '0;
    endcase
    if (w_ill) w_res = '0;
  end

  // DIVU/REMU reach this path only with b==0; a nonzero divisor iterates instead
  assign w_iter   = !w_ill && ((w_op == OP_MUL) ||
                    (((w_op == OP_DIVU) || (w_op == OP_REMU)) && (b != '0)));
  assign w_accept = in_valid && in_ready && !flush;

  assign w_acc_nxt = r_acc + (r_mpl[0] ? r_mcand : '0);
  assign w_rem_sh  = {r_rem, r_quo[XLEN-1]};
  assign w_rem_sub = w_rem_sh - {1'b0, r_div};
  assign w_ge      = !w_rem_sub[XLEN];
  assign w_rem_nxt = w_ge ? w_rem_sub[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mpl       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_is_rem    <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_illegal   <= 1'b0;
      r_operation <= OP_ADD;
    end else begin
      r_out_valid <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept && w_iter) begin
              r_state  <= (w_op == OP_MUL) ? S_MUL : S_DIV;
              r_cnt    <= CW'(XLEN-1);
              r_acc    <= '0;
              r_mcand  <= a;
              r_mpl    <= b;
              r_quo    <= a;
              r_rem    <= '0;
              r_div    <= b;
              r_is_rem <= (w_op == OP_REMU);
            end else if (w_accept) begin
              r_out_valid <= 1'b1;
              r_result    <= w_res;
              r_zero      <= (w_res == '0);
              r_illegal   <= w_ill;
              r_operation <= w_op;
            end
          end
          S_MUL: begin
            r_acc   <= w_acc_nxt;
            r_mcand <= r_mcand << 1;
            r_mpl   <= r_mpl >> 1;
            if (r_cnt == '0) begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b1;
              r_result    <= w_acc_nxt;
              r_zero      <= (w_acc_nxt == '0);
              r_illegal   <= 1'b0;
              r_operation <= OP_MUL;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_DIV: begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            if (r_cnt == '0) begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b1;
              r_result    <= r_is_rem ? w_rem_nxt : w_quo_nxt;
              r_zero      <= ((r_is_rem ? w_rem_nxt : w_quo_nxt) == '0);
              r_illegal   <= 1'b0;
              r_operation <= r_is_rem ? OP_REMU : OP_DIVU;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !reset;
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;
  assign operation = r_operation;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: scoreboard of expected results checked when out_valid pulses,
// plus an EN_MDU=0 instance for the disabled-multiplier encodings.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_valid0 = 1'b0;
  logic [1:0]  aluop = 2'b00;
  logic [4:0]  funct = 5'b00000;
  logic [31:0] a = '0, b = '0;

  logic        in_ready, out_valid, zero, illegal, busy;
  logic [31:0] result;
  logic [3:0]  operation;
  logic        in_ready0, out_valid0, zero0, illegal0, busy0;
  logic [31:0] result0;
  logic [3:0]  operation0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] last_res = '0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  op;
    logic        ill;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t me;

  alu_exec_unit #(.XLEN(32), .EN_MDU(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct(funct), .a(a), .b(b), .out_valid(out_valid), .result(result),
    .zero(zero), .illegal(illegal), .operation(operation), .busy(busy));

  alu_exec_unit #(.XLEN(32), .EN_MDU(1'b0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid0), .in_ready(in_ready0),
    .aluop(aluop), .funct(funct), .a(a), .b(b), .out_valid(out_valid0), .result(result0),
    .zero(zero0), .illegal(illegal0), .operation(operation0), .busy(busy0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every out_valid must match the oldest outstanding expectation, including its arrival cycle
  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected got res=%h op=%b at cyc=%0d want no out_valid", result, operation, cyc);
      end else begin
        me = sb.pop_front();
        last_res = me.res;
        if (result !== me.res || operation !== me.op || illegal !== me.ill ||
            zero !== (me.res == 32'd0) || cyc !== me.cyc) begin
          errors++;
          $display("FAIL out_check got res=%h op=%b ill=%b zero=%b cyc=%0d want res=%h op=%b ill=%b zero=%b cyc=%0d",
                   result, operation, illegal, zero, cyc, me.res, me.op, me.ill, (me.res == 32'd0), me.cyc);
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog simulation did not finish within 20000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [1:0] t_aluop, input logic [4:0] t_funct,
                       input logic [31:0] t_a, input logic [31:0] t_b,
                       input logic [31:0] t_res, input logic [3:0] t_op, input logic t_ill,
                       input int t_lat, input bit t_expect);
    int n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 200) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready got in_ready=%b want 1", in_ready);
    end
    aluop = t_aluop; funct = t_funct; a = t_a; b = t_b; in_valid = 1'b1;
    if (t_expect) begin
      e.res = t_res; e.op = t_op; e.ill = t_ill; e.cyc = cyc + t_lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending results want 0", sb.size());
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1 || illegal !== 1'b0 ||
        operation !== 4'b0010 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got ov=%b res=%h z=%b ill=%b op=%b busy=%b rdy=%b want 0 0 1 0 0010 0 0",
               out_valid, result, zero, illegal, operation, busy, in_ready);
    end
    checks++;
    if (result0 !== 32'd0 || zero0 !== 1'b1 || operation0 !== 4'b0010 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_mdu0 got res=%h z=%b op=%b busy=%b want 0 1 0010 0",
               result0, zero0, operation0, busy0);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_rtype();
    issue(2'b10, 5'b10000, 32'd5, 32'd7, 32'hFFFFFFFE, 4'b0110, 1'b0, 1, 1'b1);
    issue(2'b10, 5'b00000, 32'd5, 32'd7, 32'd12, 4'b0010, 1'b0, 1, 1'b1);
    issue(2'b10, 5'b00111, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 4'b0000, 1'b0, 1, 1'b1);
    issue(2'b10, 5'b00110, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 4'b0001, 1'b0, 1, 1'b1);
    issue(2'b10, 5'b00100, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 4'b0011, 1'b0, 1, 1'b1);
    issue(2'b10, 5'b00001, 32'd1, 32'h21, 32'd2, 4'b0100, 1'b0, 1, 1'b1);
    issue(2'b10, 5'b00101, 32'h80000000, 32'd31, 32'd1, 4'b0101, 1'b0, 1, 1'b1);
    issue(2'b10, 5'b10101, 32'h80000000, 32'd31, 32'hFFFFFFFF, 4'b0111, 1'b0, 1, 1'b1);
    issue(2'b10, 5'b00010, 32'hFFFFFFFF, 32'd1, 32'd1, 4'b1000, 1'b0, 1, 1'b1);
    issue(2'b10, 5'b00011, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b1001, 1'b0, 1, 1'b1);
    issue(2'b00, 5'b10101, 32'd7, 32'd7, 32'd14, 4'b0010, 1'b0, 1, 1'b1);
    issue(2'b01, 5'b00000, 32'd7, 32'd7, 32'd0, 4'b0110, 1'b0, 1, 1'b1);
    drain();
  endtask

  task automatic test_itype();
    issue(2'b11, 5'b10101, 32'h80000000, 32'd4, 32'hF8000000, 4'b0111, 1'b0, 1, 1'b1);
    issue(2'b11, 5'b00101, 32'h80000000, 32'd4, 32'h08000000, 4'b0101, 1'b0, 1, 1'b1);
    issue(2'b11, 5'b10000, 32'd5, 32'd7, 32'd12, 4'b0010, 1'b0, 1, 1'b1);
    issue(2'b11, 5'b11111, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 4'b0000, 1'b0, 1, 1'b1);
    issue(2'b11, 5'b11001, 32'd1, 32'd3, 32'd8, 4'b0100, 1'b0, 1, 1'b1);
    issue(2'b11, 5'b00010, 32'hFFFFFFFE, 32'd0, 32'd1, 4'b1000, 1'b0, 1, 1'b1);
    drain();
  endtask

  task automatic test_mul();
    issue(2'b10, 5'b01000, 32'h00012345, 32'h00000100, 32'h01234500, 4'b1010, 1'b0, 33, 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL mul_busy cycle %0d got busy=%b rdy=%b want 1 0", i, busy, in_ready);
      end
      if (i == 5) begin
        aluop = 2'b00; a = 32'd1; b = 32'd1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    drain();
    issue(2'b10, 5'b01000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b1010, 1'b0, 33, 1'b1);
    issue(2'b10, 5'b01000, 32'h0000ABCD, 32'd0, 32'd0, 4'b1010, 1'b0, 33, 1'b1);
    drain();
  endtask

  task automatic test_div();
    issue(2'b10, 5'b01101, 32'd100, 32'd7, 32'd14, 4'b1011, 1'b0, 33, 1'b1);
    issue(2'b10, 5'b01111, 32'd100, 32'd7, 32'd2, 4'b1100, 1'b0, 33, 1'b1);
    issue(2'b10, 5'b01101, 32'd100, 32'd0, 32'hFFFFFFFF, 4'b1011, 1'b0, 1, 1'b1);
    issue(2'b10, 5'b01111, 32'd100, 32'd0, 32'd100, 4'b1100, 1'b0, 1, 1'b1);
    issue(2'b10, 5'b01101, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 4'b1011, 1'b0, 33, 1'b1);
    issue(2'b10, 5'b01111, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 4'b1100, 1'b0, 33, 1'b1);
    drain();
  endtask

  task automatic test_flush();
    logic [31:0] held;
    held = last_res;
    issue(2'b10, 5'b01101, 32'd100, 32'd7, 32'd0, 4'b0, 1'b0, 0, 1'b0);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle got busy=%b rdy=%b want 0 1", busy, in_ready);
    end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (result !== held) begin
      errors++;
      $display("FAIL flush_result_held got %h want %h", result, held);
    end
    issue(2'b00, 5'b00000, 32'd1, 32'd1, 32'd2, 4'b0010, 1'b0, 1, 1'b1);
    // An op presented together with flush must not be taken
    aluop = 2'b00; a = 32'd3; b = 32'd3; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_blocks_accept got out_valid=%b want 0", out_valid);
    end
    drain();
  endtask

  task automatic test_illegal();
    issue(2'b10, 5'b11111, 32'd5, 32'd5, 32'd0, 4'b0010, 1'b1, 1, 1'b1);
    issue(2'b10, 5'b10001, 32'd5, 32'd9, 32'd0, 4'b0010, 1'b1, 1, 1'b1);
    issue(2'b10, 5'b00000, 32'd5, 32'd9, 32'd14, 4'b0010, 1'b0, 1, 1'b1);
    drain();
  endtask

  task automatic test_mdu_disabled();
    logic [4:0] fl [3];
    fl[0] = 5'b01000; fl[1] = 5'b01101; fl[2] = 5'b01111;
    for (int i = 0; i < 3; i++) begin
      aluop = 2'b10; funct = fl[i]; a = 32'd3; b = 32'd4; in_valid0 = 1'b1;
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid0 !== 1'b1 || illegal0 !== 1'b1 || result0 !== 32'd0 ||
          operation0 !== 4'b0010 || busy0 !== 1'b0) begin
        errors++;
        $display("FAIL mdu0_illegal funct=%b got ov=%b ill=%b res=%h op=%b busy=%b want 1 1 0 0010 0",
                 fl[i], out_valid0, illegal0, result0, operation0, busy0);
      end
    end
    aluop = 2'b10; funct = 5'b00000; a = 32'd3; b = 32'd4; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid0 !== 1'b1 || illegal0 !== 1'b0 || result0 !== 32'd7) begin
      errors++;
      $display("FAIL mdu0_add got ov=%b ill=%b res=%h want 1 0 7", out_valid0, illegal0, result0);
    end
  endtask

  task automatic test_random();
    logic [31:0] ra, rb, er;
    logic [4:0]  f;
    logic [3:0]  op;
    int lat, sel;
    for (int i = 0; i < 24; i++) begin
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      sel = $urandom_range(0, 5);
      lat = 1;
      case (sel)
        0: begin f = 5'b00000; op = 4'b0010; er = ra + rb; end
        1: begin f = 5'b10000; op = 4'b0110; er = ra - rb; end
        2: begin f = 5'b00100; op = 4'b0011; er = ra ^ rb; end
        3: begin f = 5'b01000; op = 4'b1010; er = ra * rb; lat = 33; end
        4: begin f = 5'b01101; op = 4'b1011;
                 er = (rb == 0) ? 32'hFFFFFFFF : ra / rb; lat = (rb == 0) ? 1 : 33; end
        default: begin f = 5'b01111; op = 4'b1100;
                 er = (rb == 0) ? ra : ra % rb; lat = (rb == 0) ? 1 : 33; end
      endcase
      issue(2'b10, f, ra, rb, er, op, 1'b0, lat, 1'b1);
    end
    drain();
  endtask

  task automatic test_reset_mid_mul();
    issue(2'b10, 5'b01000, 32'd9, 32'd9, 32'd0, 4'b0, 1'b0, 0, 1'b0);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1 ||
        operation !== 4'b0010 || illegal !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_mul got busy=%b ov=%b res=%h z=%b op=%b ill=%b rdy=%b want 0 0 0 1 0010 0 0",
               busy, out_valid, result, zero, operation, illegal, in_ready);
    end
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_mul_after got rdy=%b res=%h want 1 0", in_ready, result);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_mul();
    test_div();
    test_flush();
    test_illegal();
    test_mdu_disabled();
    test_random();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
